// File: rtl/config_seq_pkg.sv
// Shared definitions for the camera-configuration table walker: opcodes,
// entry field positions (also used by the config-memory loader) and the FSM states.
package config_seq_pkg;

  localparam logic [7:0] OP_WRITE = 8'h00;
  localparam logic [7:0] OP_DELAY = 8'h01;
  localparam logic [7:0] OP_END   = 8'hFF;

  localparam int ENTRY_W = 24;
  localparam int OP_MSB  = 23;
  localparam int OP_LSB  = 16;
  localparam int REG_MSB = 15;
  localparam int REG_LSB = 8;
  localparam int VAL_MSB = 7;
  localparam int VAL_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DELAY = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic [7:0] entry_op(input logic [ENTRY_W-1:0] e);
    return e[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [7:0] entry_reg(input logic [ENTRY_W-1:0] e);
    return e[REG_MSB:REG_LSB];
  endfunction

  function automatic logic [7:0] entry_val(input logic [ENTRY_W-1:0] e);
    return e[VAL_MSB:VAL_LSB];
  endfunction

endpackage

// File: rtl/config_sequencer_ms_delay_timer.sv
// Millisecond delay timer: load with a millisecond count, then count down one
// tick per clock; expire is high on the final cycle of the delay.
module ms_delay_timer #(
  parameter int TICKS_PER_MS = 25000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] ms,
  output logic       expire
);

  localparam int CW = $clog2(255 * TICKS_PER_MS);

  logic [CW-1:0] cnt;
  logic          running;
  logic [CW-1:0] load_val;

  // N ms lasts N*TICKS_PER_MS cycles, counted N*TICKS_PER_MS-1 down to 0.
  // The caller never loads ms=0.
  assign load_val = CW'(ms) * CW'(TICKS_PER_MS) - CW'(1);
  assign expire   = running && (cnt == '0);

  // Counter register: load, count down while running, stop at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (load) begin
      cnt     <= load_val;
      running <= 1'b1;
    end else if (running) begin
      if (cnt == '0) running <= 1'b0;
      else           cnt     <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/config_sequencer.sv
// Walks the camera configuration table after start, issuing register writes to
// the SCCB master, honouring delay entries and stopping at END, an illegal
// opcode, a NACK or the last table address.
//
// SCCB handshake: sccb_req rises with sccb_reg/sccb_val and all three stay
// stable until the clock edge where sccb_ack=1; sccb_nack is meaningful only
// together with sccb_ack, and ack/nack are ignored outside ISSUE.
module config_sequencer
  import config_seq_pkg::*;
#(
  parameter int ENTRY_COUNT  = 256,
  parameter int TICKS_PER_MS = 25000,
  localparam int AW = $clog2(ENTRY_COUNT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [AW-1:0]      r_addr,
  input  logic [ENTRY_W-1:0] r_data,
  output logic               sccb_req,
  output logic [7:0]         sccb_reg,
  output logic [7:0]         sccb_val,
  input  logic               sccb_ack,
  input  logic               sccb_nack,
  output logic               busy,
  output logic               done,
  output logic               error,
  output state_t             state_dbg
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(ENTRY_COUNT - 1);

  state_t        state, state_d;
  logic [AW-1:0] r_addr_d;
  logic          sccb_req_d;
  logic [7:0]    sccb_reg_d, sccb_val_d;
  logic          busy_d, done_d, error_d;
  logic          timer_load, timer_expire;
  logic          do_advance, do_finish, finish_err;

  assign state_dbg = state;

  ms_delay_timer #(.TICKS_PER_MS(TICKS_PER_MS)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .ms     (entry_val(r_data)),
    .expire (timer_expire)
  );

  // State and registered outputs; reset clears everything, including a pending request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      r_addr   <= '0;
      sccb_req <= 1'b0;
      sccb_reg <= '0;
      sccb_val <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_d;
      r_addr   <= r_addr_d;
      sccb_req <= sccb_req_d;
      sccb_reg <= sccb_reg_d;
      sccb_val <= sccb_val_d;
      busy     <= busy_d;
      done     <= done_d;
      error    <= error_d;
    end
  end

  // Next state and next output values; advance/finish are shared tails.
  always_comb begin
    state_d    = state;
    r_addr_d   = r_addr;
    sccb_req_d = sccb_req;
    sccb_reg_d = sccb_reg;
    sccb_val_d = sccb_val;
    busy_d     = busy;
    done_d     = done;
    error_d    = error;
    timer_load = 1'b0;
    do_advance = 1'b0;
    do_finish  = 1'b0;
    finish_err = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          r_addr_d = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          error_d  = 1'b0;
          state_d  = ST_FETCH;
        end
      end
      ST_FETCH: begin
        case (entry_op(r_data))
          OP_WRITE: begin
            sccb_reg_d = entry_reg(r_data);
            sccb_val_d = entry_val(r_data);
            sccb_req_d = 1'b1;
            state_d    = ST_ISSUE;
          end
          OP_DELAY: begin
            if (entry_val(r_data) != 8'd0) begin
              timer_load = 1'b1;
              state_d    = ST_DELAY;
            end else begin
              do_advance = 1'b1;
            end
          end
          OP_END: begin
            do_finish = 1'b1;
          end
          default: begin
            do_finish  = 1'b1;
            finish_err = 1'b1;
          end
        endcase
      end
      ST_ISSUE: begin
        if (sccb_ack) begin
          sccb_req_d = 1'b0;
          if (sccb_nack) begin
            do_finish  = 1'b1;
            finish_err = 1'b1;
          end else begin
            do_advance = 1'b1;
          end
        end
      end
      ST_DELAY: begin
        if (timer_expire) do_advance = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // A table without a terminator ends cleanly at its last address.
    if (do_advance) begin
      if (r_addr == LAST_ADDR) begin
        do_finish = 1'b1;
      end else begin
        r_addr_d = r_addr + AW'(1);
        state_d  = ST_FETCH;
      end
    end

    if (do_finish) begin
      state_d = ST_DONE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      error_d = finish_err;
    end
  end

endmodule

// File: tb/tb_config_sequencer.sv
// Directed bench for config_sequencer: a behavioural config memory, an SCCB
// responder inside run_walk, and an expected-transaction queue per scenario.
module tb_config_sequencer;
  import config_seq_pkg::*;

  localparam int TPM = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        sccb_ack = 1'b0;
  logic        sccb_nack = 1'b0;
  logic [7:0]  r_addr, sccb_reg, sccb_val;
  logic [23:0] r_data;
  logic        sccb_req, busy, done, error;
  state_t      state_dbg;

  logic [23:0] mem [256];
  assign r_data = mem[r_addr];

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_q[$];
  logic [23:0] txn_q[$];
  int delay_cycles, first_req_cycle, done_cycle, gap_bad, hold_bad, max_addr;

  config_sequencer #(.ENTRY_COUNT(256), .TICKS_PER_MS(TPM)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .r_addr    (r_addr),
    .r_data    (r_data),
    .sccb_req  (sccb_req),
    .sccb_reg  (sccb_reg),
    .sccb_val  (sccb_val),
    .sccb_ack  (sccb_ack),
    .sccb_nack (sccb_nack),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .state_dbg (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; sccb_ack = 1'b0; sccb_nack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill(input logic [23:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  // Start is sampled at the edge after the first negedge below.
  task automatic start_walk();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Observes the walk at negedges, answers requests after ack_delay sampled
  // high cycles (0 = never), NACKs transaction nack_idx, optionally pulses
  // start at sample start_at. Stops at done or after budget samples.
  task automatic run_walk(input int budget, input int ack_delay, input int nack_idx,
                          input int start_at);
    int hi_cnt, low_cnt;
    logic prev_req, acked_prev, seen_done;
    logic [7:0] h_reg, h_val;
    txn_q.delete();
    delay_cycles = 0; first_req_cycle = -1; done_cycle = -1;
    gap_bad = 0; hold_bad = 0; max_addr = 0;
    hi_cnt = 0; low_cnt = 0; prev_req = 1'b0; acked_prev = 1'b0; seen_done = 1'b0;
    h_reg = '0; h_val = '0;
    for (int cyc = 1; cyc <= budget && !seen_done; cyc++) begin
      @(negedge clk);
      sccb_ack = 1'b0; sccb_nack = 1'b0;
      start = (cyc == start_at);
      if (int'(r_addr) > max_addr) max_addr = int'(r_addr);
      if (state_dbg == ST_DELAY) delay_cycles++;
      if (done) begin
        seen_done = 1'b1;
        done_cycle = cyc;
      end else if (sccb_req) begin
        if (!prev_req || acked_prev) begin
          if (first_req_cycle < 0) first_req_cycle = cyc;
          if (txn_q.size() > 0 && low_cnt != 1) gap_bad++;
          h_reg = sccb_reg; h_val = sccb_val; hi_cnt = 0;
        end else if (sccb_reg !== h_reg || sccb_val !== h_val) begin
          hold_bad++;
        end
        low_cnt = 0;
        hi_cnt++;
        acked_prev = 1'b0;
        if (ack_delay > 0 && hi_cnt == ack_delay) begin
          sccb_ack = 1'b1;
          sccb_nack = (txn_q.size() == nack_idx);
          txn_q.push_back({r_addr, sccb_reg, sccb_val});
          acked_prev = 1'b1;
        end
      end else begin
        low_cnt++;
        acked_prev = 1'b0;
      end
      prev_req = sccb_req;
    end
    sccb_ack = 1'b0; sccb_nack = 1'b0; start = 1'b0;
    checks++;
    if (!seen_done) begin
      errors++;
      $display("FAIL walk_timeout: done=%0b after %0d cycles, required 1", done, budget);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({r_addr, sccb_req, sccb_reg, sccb_val, busy, done, error} !== 28'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0",
               {r_addr, sccb_req, sccb_reg, sccb_val, busy, done, error});
    end
    checks++;
    if (state_dbg !== ST_IDLE) begin
      errors++; $display("FAIL reset_state: got %0d, required %0d", state_dbg, ST_IDLE);
    end
    rst = 1'b0;
  endtask

  task automatic test_write_table();
    do_reset();
    fill(24'hFF_00_00);
    mem[0] = 24'h00_12_80; mem[1] = 24'h00_11_01; mem[2] = 24'hFF_00_00;
    exp_q = '{24'h00_12_80, 24'h01_11_01};
    start_walk();
    checks++;
    if (busy !== 1'b1 || sccb_req !== 1'b0) begin
      errors++; $display("FAIL wr_accept: busy=%0b req=%0b, required busy=1 req=0", busy, sccb_req);
    end
    run_walk(100, 3, -1, 0);
    checks++;
    if (first_req_cycle !== 1) begin
      errors++; $display("FAIL wr_latency: got %0d, required 1", first_req_cycle);
    end
    checks++;
    if (txn_q.size() != exp_q.size()) begin
      errors++; $display("FAIL wr_count: got %0d, required %0d", txn_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (txn_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL wr_txn%0d: got %h, required %h", i, txn_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if ({done, error, busy} !== 3'b100 || r_addr !== 8'd2) begin
      errors++;
      $display("FAIL wr_final: done/err/busy=%b addr=%0d, required 100 addr=2", {done, error, busy}, r_addr);
    end
    checks++;
    if (gap_bad != 0 || hold_bad != 0) begin
      errors++; $display("FAIL wr_handshake: gap_bad=%0d hold_bad=%0d, required 0 0", gap_bad, hold_bad);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL wr_done_hold: done=%0b busy=%0b, required 1 0", done, busy);
    end
  endtask

  task automatic test_delay();
    do_reset();
    fill(24'hFF_00_00);
    mem[0] = 24'h01_00_02;
    start_walk();
    run_walk(100, 3, -1, 0);
    checks++;
    if (delay_cycles != 2 * TPM) begin
      errors++; $display("FAIL dly_cycles: got %0d, required %0d", delay_cycles, 2 * TPM);
    end
    checks++;
    if (first_req_cycle != -1) begin
      errors++; $display("FAIL dly_no_req: req seen at %0d, required none", first_req_cycle);
    end
    checks++;
    if ({done, error} !== 2'b10 || r_addr !== 8'd1) begin
      errors++; $display("FAIL dly_final: done/err=%b addr=%0d, required 10 addr=1", {done, error}, r_addr);
    end
  endtask

  task automatic test_zero_delay_and_start_in_delay();
    do_reset();
    fill(24'hFF_00_00);
    mem[0] = 24'h01_00_00;
    mem[1] = 24'h01_00_01;
    start_walk();
    run_walk(100, 3, -1, 5);
    checks++;
    if (delay_cycles != TPM) begin
      errors++; $display("FAIL sid_cycles: got %0d, required %0d", delay_cycles, TPM);
    end
    checks++;
    if ({done, error} !== 2'b10 || r_addr !== 8'd2) begin
      errors++; $display("FAIL sid_final: done/err=%b addr=%0d, required 10 addr=2", {done, error}, r_addr);
    end
  endtask

  task automatic test_nack();
    do_reset();
    fill(24'hFF_00_00);
    for (int i = 0; i < 5; i++) mem[i] = {8'h00, 8'h20 + 8'(i), 8'(i)};
    exp_q = '{24'h00_20_00, 24'h01_21_01, 24'h02_22_02, 24'h03_23_03};
    start_walk();
    run_walk(200, 2, 3, 0);
    checks++;
    if (txn_q.size() != exp_q.size()) begin
      errors++; $display("FAIL nack_count: got %0d, required %0d", txn_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (txn_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL nack_txn%0d: got %h, required %h", i, txn_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if ({done, error, sccb_req} !== 3'b110 || r_addr !== 8'd3 || max_addr != 3) begin
      errors++;
      $display("FAIL nack_final: done/err/req=%b addr=%0d max=%0d, required 110 addr=3 max=3",
               {done, error, sccb_req}, r_addr, max_addr);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    fill(24'hFF_00_00);
    mem[0] = 24'h7E_00_00;
    start_walk();
    run_walk(20, 3, -1, 0);
    checks++;
    if (done_cycle != 1) begin
      errors++; $display("FAIL ill_latency: done at %0d, required 1", done_cycle);
    end
    checks++;
    if ({done, error, busy} !== 3'b110 || r_addr !== 8'd0 || first_req_cycle != -1) begin
      errors++;
      $display("FAIL ill_final: done/err/busy=%b addr=%0d req_at=%0d, required 110 addr=0 none",
               {done, error, busy}, r_addr, first_req_cycle);
    end
  endtask

  task automatic test_full_table();
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      mem[i] = {8'h00, 8'h40, 8'(i)};
      exp_q.push_back({8'(i), 8'h40, 8'(i)});
    end
    start_walk();
    run_walk(2000, 1, -1, 0);
    checks++;
    if (txn_q.size() != 256) begin
      errors++; $display("FAIL full_count: got %0d, required 256", txn_q.size());
    end else begin
      checks++;
      if (txn_q != exp_q) begin
        errors++; $display("FAIL full_txns: last got %h, required %h", txn_q[255], exp_q[255]);
      end
    end
    checks++;
    if ({done, error} !== 2'b10 || r_addr !== 8'd255 || gap_bad != 0) begin
      errors++;
      $display("FAIL full_final: done/err=%b addr=%0d gap_bad=%0d, required 10 addr=255 0",
               {done, error}, r_addr, gap_bad);
    end
  endtask

  task automatic test_reset_mid_walk();
    do_reset();
    fill(24'h00_55_AA);
    start_walk();
    for (int i = 0; i < 10 && !sccb_req; i++) @(negedge clk);
    checks++;
    if (sccb_req !== 1'b1) begin
      errors++; $display("FAIL rstm_req_up: got %0b, required 1", sccb_req);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({r_addr, sccb_req, sccb_reg, sccb_val, busy, done, error} !== 28'd0 || state_dbg !== ST_IDLE) begin
      errors++;
      $display("FAIL rstm_outputs: got %h state %0d, required 0 state 0",
               {r_addr, sccb_req, sccb_reg, sccb_val, busy, done, error}, state_dbg);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || state_dbg !== ST_IDLE) begin
      errors++; $display("FAIL rst_beats_start: busy=%0b state=%0d, required 0 0", busy, state_dbg);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, sccb_req} !== 3'b000) begin
      errors++; $display("FAIL rstm_idle: busy/done/req=%b, required 000", {busy, done, sccb_req});
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 24'hFF_00_00;
    test_reset();
    test_write_table();
    test_delay();
    test_zero_delay_and_start_in_delay();
    test_nack();
    test_illegal();
    test_full_table();
    test_reset_mid_walk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
